// File: rtl/count_ser_pkg.sv
// Shared types and constants for the count serializer: FSM state encoding,
// frame geometry and the parity helper used when a value is loaded.
package count_ser_pkg;

  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ser_state_e;

  typedef logic [DATA_BITS-1:0] data_t;

  function automatic logic even_parity(input data_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/count_fifo.sv
// Capture FIFO for count values. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module count_fifo
  import count_ser_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  data_t       wdata,
  output data_t       rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  data_t       mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A pop on the same edge frees the slot, so a push to a full FIFO is still taken.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers already
  // discards its contents, and unreset memory maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/count_serializer.sv
// Captures changes of an upstream 4-bit counter into a FIFO and transmits
// each value as a start / 4 data (LSB first) / even parity / stop frame.
module count_serializer
  import count_ser_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               count,
  input  logic                     sample_en,
  input  logic                     clr_ovf,
  output logic                     ser_out,
  output logic                     busy,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);

  ser_state_e       state_q,    state_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [BIT_W-1:0] bit_q,      bit_d;
  data_t            shift_q,    shift_d;
  logic             parity_q,   parity_d;
  logic             ser_out_q,  ser_out_d;
  logic             busy_q,     busy_d;
  logic             ovf_q,      ovf_d;
  data_t            last_cap_q, last_cap_d;

  logic  capture;
  logic  div_last;
  logic  fifo_pop;
  logic  fifo_full;
  logic  fifo_empty;
  data_t fifo_rdata;

  count_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (fifo_pop),
    .wdata (count),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // last_cap follows every capture, including ones dropped on a full FIFO.
  always_comb begin
    capture    = sample_en && (count != last_cap_q);
    last_cap_d = capture ? count : last_cap_q;
    if (capture && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    fifo_pop = 1'b0;
    div_last = (div_q == DIV_W'(CLK_DIV - 1));

    if (state_q != ST_IDLE) begin
      div_d = div_last ? '0 : div_q + DIV_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          parity_d = even_parity(fifo_rdata);
          div_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (div_last) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (div_last) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_PARITY;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (div_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Chain straight into the next frame when data is already waiting.
        if (div_last) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            parity_d = even_parity(fifo_rdata);
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state so ser_out changes on the edge
  // that enters each bit, not one cycle later.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_START:  ser_out_d = 1'b0;
      ST_DATA:   ser_out_d = shift_d[0];
      ST_PARITY: ser_out_d = parity_d;
      default:   ser_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      ser_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      last_cap_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      ser_out_q  <= ser_out_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      last_cap_q <= last_cap_d;
    end
  end

  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule
